// File: rtl/div_ctrl.sv
// div_ctrl: EX-stage initiator for the multi-cycle radix-2 divider.
// Issues DIV/DIVU with held operands, stalls IF/ID/EX until the divider is
// ready, captures {HI,LO}, and annuls/drains the divider on a pipeline flush
// so a stale result never reaches HI/LO.
// Optional build macro DIV_TRIVIAL_BYPASS_EN: resolves divisor==1 and
// dividend==0 locally without starting the divider.
`timescale 1ns/1ps

module div_ctrl #(
  parameter int unsigned DRAIN_CYC = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_div_i,
  input  logic        ex_divu_i,
  input  logic [31:0] ex_src_a_i,
  input  logic [31:0] ex_src_b_i,
  input  logic        flush_i,
  input  logic        ex_hold_i,
  input  logic        div_ready_i,
  input  logic [63:0] div_result_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  output logic        stall_div_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = $clog2(DRAIN_CYC + 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYC - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          start_q, start_d;
  logic          signed_q, signed_d;
  logic [DW-1:0] op1_q, op1_d;
  logic [DW-1:0] op2_q, op2_d;
  logic          we_q, we_d;
  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;
  logic          stall_c;
  logic          req;

  // A flushed EX instruction never counts as a divide request.
  assign req = (ex_div_i | ex_divu_i) & ~flush_i;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      signed_q <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      we_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      signed_q <= signed_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      we_q     <= we_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Next state, registered-output next values and combinational stall.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    start_d  = 1'b0;
    signed_d = signed_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    we_d     = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    stall_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        stall_c = req;
        if (req) begin
          op1_d    = ex_src_a_i;
          op2_d    = ex_src_b_i;
          signed_d = ex_div_i;
`ifdef DIV_TRIVIAL_BYPASS_EN
          if (ex_src_b_i == 32'd1) begin
            hi_d    = '0;
            lo_d    = ex_src_a_i;
            we_d    = 1'b1;
            state_d = S_DONE;
          end else if (ex_src_a_i == 32'd0) begin
            hi_d    = '0;
            lo_d    = '0;
            we_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            start_d = 1'b1;
            state_d = S_BUSY;
          end
`else
          start_d = 1'b1;
          state_d = S_BUSY;
`endif
        end
      end

      S_BUSY: begin
        // Flush wins over a same-cycle ready: the result is dropped.
        if (flush_i) begin
          cnt_d   = DRAIN_LOAD;
          state_d = S_DRAIN;
        end else begin
          stall_c = 1'b1;
          if (div_ready_i) begin
            hi_d    = div_result_i[63:32];
            lo_d    = div_result_i[31:0];
            we_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            start_d = 1'b1;
          end
        end
      end

      S_DONE: begin
        // start low here gives the divider its return-to-free cycle.
        if (flush_i) begin
          cnt_d   = DRAIN_LOAD;
          state_d = S_DRAIN;
        end else if (ex_hold_i) begin
          we_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_DRAIN: begin
        // Hold any new request until the divider has fully wound down.
        stall_c = req;
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign div_start_o  = start_q;
  assign div_annul_o  = flush_i;
  assign div_signed_o = signed_q;
  assign div_op1_o    = op1_q;
  assign div_op2_o    = op2_q;
  assign stall_div_o  = stall_c & rst;
  assign hilo_we_o    = we_q & ~flush_i;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;

endmodule
